// File: rtl/four_digit_updown_ctrl.sv
// Four-digit BCD up/down counter with tick prescaler and multiplexed
// seven-segment scan. Drives one shared digit decoder plus four anodes.
module four_digit_updown_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        upDown,
  input  logic        load,
  input  logic [15:0] loadValue,
  input  logic        blankEn,
  output logic [15:0] value,
  output logic        tick,
  output logic [3:0]  digitOut,
  output logic [3:0]  anode
);

  localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
  localparam int          SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic [31:0]       prescCnt;
  logic              tickInt;
  logic [15:0]       nextValue;
  logic [15:0]       loadClean;
  logic [SCAN_W-1:0] scanCnt;
  logic [1:0]        digitSel;
  logic [3:0]        blankMask;
  logic [3:0]        selDigit;
  logic [3:0]        selAnode;

  // A count tick happens only while running, on the last prescaler state
  always_comb begin
    tickInt = run && (prescCnt == TICK_LAST);
  end

  // Prescaler: load restarts the period, run=0 freezes it
  always_ff @(posedge clk) begin
    if (rst) begin
      prescCnt <= '0;
    end else if (load) begin
      prescCnt <= '0;
    end else if (tickInt) begin
      prescCnt <= '0;
    end else if (run) begin
      prescCnt <= prescCnt + 32'd1;
    end
  end

  // Ripple carry/borrow through the four BCD digits for the next count
  always_comb begin
    logic       chain;
    logic [3:0] d;
    nextValue = value;
    chain     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = value[i*4 +: 4];
      if (chain) begin
        if (upDown) begin
          if (d >= 4'd9) begin
            nextValue[i*4 +: 4] = 4'd0;
            chain               = 1'b1;
          end else begin
            nextValue[i*4 +: 4] = d + 4'd1;
            chain               = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            nextValue[i*4 +: 4] = 4'd9;
            chain               = 1'b1;
          end else if (d > 4'd9) begin
            nextValue[i*4 +: 4] = 4'd8;
            chain               = 1'b0;
          end else begin
            nextValue[i*4 +: 4] = d - 4'd1;
            chain               = 1'b0;
          end
        end
      end
    end
  end

  // Any non-decimal nibble in the load word is forced to zero
  always_comb begin
    loadClean = '0;
    for (int i = 0; i < 4; i++) begin
      if (loadValue[i*4 +: 4] <= 4'd9) begin
        loadClean[i*4 +: 4] = loadValue[i*4 +: 4];
      end
    end
  end

  // Count register and tick flag: load wins over a coincident tick
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= 16'h0000;
      tick  <= 1'b0;
    end else if (load) begin
      value <= loadClean;
      tick  <= 1'b0;
    end else if (tickInt) begin
      value <= nextValue;
      tick  <= 1'b1;
    end else begin
      tick  <= 1'b0;
    end
  end

  // Leading-zero blanking mask; the ones digit is always shown
  always_comb begin
    blankMask    = 4'b0000;
    blankMask[3] = blankEn && (value[15:12] == 4'd0);
    blankMask[2] = blankMask[3] && (value[11:8] == 4'd0);
    blankMask[1] = blankMask[2] && (value[7:4] == 4'd0);
  end

  // Scan timer steps the digit select once per slot period
  always_ff @(posedge clk) begin
    if (rst) begin
      scanCnt  <= '0;
      digitSel <= 2'd0;
    end else if (scanCnt == SCAN_LAST) begin
      scanCnt  <= '0;
      digitSel <= digitSel + 2'd1;
    end else begin
      scanCnt  <= scanCnt + SCAN_W'(1);
    end
  end

  // Pick the digit and anode for the current slot, honouring blanking
  always_comb begin
    selDigit = value[digitSel*4 +: 4];
    selAnode = 4'(4'b0001 << digitSel);
    if (blankMask[digitSel]) begin
      selDigit = 4'h0;
      selAnode = 4'b0000;
    end
  end

  // Anode and digit leave through a common register so they stay aligned
  always_ff @(posedge clk) begin
    if (rst) begin
      anode    <= 4'b0001;
      digitOut <= 4'h0;
    end else begin
      anode    <= selAnode;
      digitOut <= selDigit;
    end
  end

endmodule
